// File: rtl/ysyx_22040895_wbu.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | ysyx_22040895_wbu : writeback arbiter, load extender, regfile write    |
// | stage and per-register pending-write scoreboard.        Rev 1.0        |
// +------------------------------------------------------------------------+
module ysyx_22040895_wbu #(
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid_i,
  output logic        alu_ready_o,
  input  logic        alu_wen_i,
  input  logic [4:0]  alu_rd_i,
  input  logic [63:0] alu_data_i,
  input  logic        lsu_valid_i,
  output logic        lsu_ready_o,
  input  logic [4:0]  lsu_rd_i,
  input  logic [1:0]  lsu_size_i,
  input  logic        lsu_unsigned_i,
  input  logic [2:0]  lsu_offset_i,
  input  logic [63:0] lsu_rdata_i,
  input  logic        alloc_valid_i,
  output logic        alloc_ready_o,
  input  logic [4:0]  alloc_rd_i,
  input  logic [4:0]  rs1_addr_i,
  input  logic [4:0]  rs2_addr_i,
  output logic        rs1_busy_o,
  output logic        rs2_busy_o,
  output logic        we_o_reg,
  output logic [4:0]  waddr_o_reg,
  output logic [63:0] wdata_o_reg,
  output logic        idle_o
);
  localparam logic [3:0]       STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [CNT_W-1:0] CNT_FULL   = '1;

  logic [3:0]       starve_q, starve_d;
  logic             we_q, we_d;
  logic [4:0]       waddr_q, waddr_d;
  logic [63:0]      wdata_q, wdata_d;
  logic [CNT_W-1:0] cnt_q [32];
  logic [CNT_W-1:0] cnt_d [32];

  logic        force_alu, grant_alu, grant_lsu;
  logic        alu_xfer, lsu_xfer, alloc_xfer, sx, any_pend;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_w;
  logic [63:0] ld_ext;
  logic [31:0] inc_vec, dec_vec;

  // LSU wins unless the ALU has already lost STARVE_MAX cycles in a row.
  always_comb begin
    force_alu = alu_valid_i && (starve_q == STARVE_LIM);
    grant_lsu = lsu_valid_i && !force_alu;
    grant_alu = alu_valid_i && !grant_lsu;
  end

  assign alu_ready_o   = rst && grant_alu;
  assign lsu_ready_o   = rst && grant_lsu;
  assign alloc_ready_o = rst && (cnt_q[alloc_rd_i] != CNT_FULL);
  assign alu_xfer      = alu_valid_i && alu_ready_o;
  assign lsu_xfer      = lsu_valid_i && lsu_ready_o;
  assign alloc_xfer    = alloc_valid_i && alloc_ready_o && (alloc_rd_i != 5'd0);

  always_comb begin
    ld_b = lsu_rdata_i[{lsu_offset_i, 3'b000} +: 8];
    ld_h = lsu_rdata_i[{lsu_offset_i[2:1], 4'b0000} +: 16];
    ld_w = lsu_rdata_i[{lsu_offset_i[2], 5'b00000} +: 32];
    sx   = !lsu_unsigned_i;
    case (lsu_size_i)
      2'd0:    ld_ext = {{56{sx & ld_b[7]}}, ld_b};
      2'd1:    ld_ext = {{48{sx & ld_h[15]}}, ld_h};
      2'd2:    ld_ext = {{32{sx & ld_w[31]}}, ld_w};
      default: ld_ext = lsu_rdata_i;
    endcase
  end

  always_comb begin
    starve_d = 4'd0;
    if (alu_valid_i && !alu_xfer)
      starve_d = (starve_q == 4'hF) ? starve_q : starve_q + 4'd1;

    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (alu_xfer && alu_wen_i && (alu_rd_i != 5'd0)) begin
      we_d    = 1'b1;
      waddr_d = alu_rd_i;
      wdata_d = alu_data_i;
    end else if (lsu_xfer && (lsu_rd_i != 5'd0)) begin
      we_d    = 1'b1;
      waddr_d = lsu_rd_i;
      wdata_d = ld_ext;
    end
  end

  // A simultaneous allocate and retire of one register cancels out.
  always_comb begin
    inc_vec = alloc_xfer ? (32'd1 << alloc_rd_i) : 32'd0;
    dec_vec = we_q ? (32'd1 << waddr_q) : 32'd0;
    for (int i = 0; i < 32; i++) begin
      cnt_d[i] = cnt_q[i];
      if (i == 0)
        cnt_d[i] = '0;
      else if (inc_vec[i] && !dec_vec[i])
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      else if (dec_vec[i] && !inc_vec[i] && (cnt_q[i] != '0))
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
    end
  end

  always_comb begin
    any_pend = 1'b0;
    for (int i = 1; i < 32; i++)
      any_pend = any_pend | (cnt_q[i] != '0);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      starve_q <= 4'd0;
      we_q     <= 1'b0;
      waddr_q  <= 5'd0;
      wdata_q  <= 64'd0;
      for (int i = 0; i < 32; i++)
        cnt_q[i] <= '0;
    end else begin
      starve_q <= starve_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      for (int i = 0; i < 32; i++)
        cnt_q[i] <= cnt_d[i];
    end
  end

  assign rs1_busy_o  = (cnt_q[rs1_addr_i] != '0);
  assign rs2_busy_o  = (cnt_q[rs2_addr_i] != '0);
  assign idle_o      = !any_pend && !we_q;
  assign we_o_reg    = we_q;
  assign waddr_o_reg = waddr_q;
  assign wdata_o_reg = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22040895_wbu.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_ysyx_22040895_wbu : directed and randomized bench for the wbu.      |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module tb_ysyx_22040895_wbu;
  localparam int STARVE_MAX = 4;
  localparam int CNT_W      = 2;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid_i, alu_wen_i;
  logic [4:0]  alu_rd_i;
  logic [63:0] alu_data_i;
  logic        lsu_valid_i, lsu_unsigned_i;
  logic [4:0]  lsu_rd_i;
  logic [1:0]  lsu_size_i;
  logic [2:0]  lsu_offset_i;
  logic [63:0] lsu_rdata_i;
  logic        alloc_valid_i;
  logic [4:0]  alloc_rd_i, rs1_addr_i, rs2_addr_i;
  logic        alu_ready_o, lsu_ready_o, alloc_ready_o;
  logic        rs1_busy_o, rs2_busy_o, we_o_reg, idle_o;
  logic [4:0]  waddr_o_reg;
  logic [63:0] wdata_o_reg;

  ysyx_22040895_wbu #(.STARVE_MAX(STARVE_MAX), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .alu_valid_i(alu_valid_i), .alu_ready_o(alu_ready_o), .alu_wen_i(alu_wen_i),
    .alu_rd_i(alu_rd_i), .alu_data_i(alu_data_i),
    .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o), .lsu_rd_i(lsu_rd_i),
    .lsu_size_i(lsu_size_i), .lsu_unsigned_i(lsu_unsigned_i),
    .lsu_offset_i(lsu_offset_i), .lsu_rdata_i(lsu_rdata_i),
    .alloc_valid_i(alloc_valid_i), .alloc_ready_o(alloc_ready_o), .alloc_rd_i(alloc_rd_i),
    .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
    .rs1_busy_o(rs1_busy_o), .rs2_busy_o(rs2_busy_o),
    .we_o_reg(we_o_reg), .waddr_o_reg(waddr_o_reg), .wdata_o_reg(wdata_o_reg),
    .idle_o(idle_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic cmp_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: pending-write counts as integers, ALU wait as a plain count.
  int          pend [32];
  int          starve = 0;
  logic        m_we;
  logic [4:0]  m_waddr;
  logic [63:0] m_wdata;
  logic        m_alu_took = 1'b0;
  logic        m_lsu_took = 1'b0;

  function automatic logic exp_alu_ready();
    return rst && alu_valid_i && (!lsu_valid_i || starve == STARVE_MAX);
  endfunction

  function automatic logic exp_lsu_ready();
    return rst && lsu_valid_i && !(alu_valid_i && starve == STARVE_MAX);
  endfunction

  function automatic logic exp_alloc_ready();
    return rst && (alloc_rd_i == 5'd0 || pend[alloc_rd_i] < CNT_MAX);
  endfunction

  function automatic logic [63:0] load_val(input logic [63:0] rdata, input logic [1:0] size,
                                           input logic uns, input logic [2:0] off);
    int          nbytes = 1 << size;
    int          pos    = (int'(off) / nbytes) * nbytes;
    logic [63:0] v      = rdata >> (pos * 8);
    logic [63:0] mask;
    if (nbytes < 8) begin
      mask = (64'd1 << (nbytes * 8)) - 64'd1;
      v    = v & mask;
      if (!uns && v[nbytes*8-1]) v = v | ~mask;
    end
    return v;
  endfunction

  function automatic logic model_idle();
    for (int i = 0; i < 32; i++)
      if (pend[i] != 0) return 1'b0;
    return !m_we;
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) pend[i] = 0;
      starve     = 0;
      m_we       = 1'b0;
      m_waddr    = 5'd0;
      m_wdata    = 64'd0;
      m_alu_took = 1'b0;
      m_lsu_took = 1'b0;
    end else begin
      logic a, l, al;
      a  = exp_alu_ready();
      l  = exp_lsu_ready();
      al = alloc_valid_i && exp_alloc_ready() && alloc_rd_i != 5'd0;
      if (al) pend[alloc_rd_i] = pend[alloc_rd_i] + 1;
      if (m_we && m_waddr != 5'd0 && pend[m_waddr] > 0) pend[m_waddr] = pend[m_waddr] - 1;
      starve = (alu_valid_i && !a) ? starve + 1 : 0;
      if (a && alu_wen_i && alu_rd_i != 5'd0) begin
        m_we = 1'b1; m_waddr = alu_rd_i; m_wdata = alu_data_i;
      end else if (l && lsu_rd_i != 5'd0) begin
        m_we = 1'b1; m_waddr = lsu_rd_i;
        m_wdata = load_val(lsu_rdata_i, lsu_size_i, lsu_unsigned_i, lsu_offset_i);
      end else begin
        m_we = 1'b0;
      end
      m_alu_took = a;
      m_lsu_took = l;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("we", we_o_reg, m_we);
      chk("waddr", waddr_o_reg, m_waddr);
      chk("wdata", wdata_o_reg, m_wdata);
      chk("alu_ready", alu_ready_o, exp_alu_ready());
      chk("lsu_ready", lsu_ready_o, exp_lsu_ready());
      chk("alloc_ready", alloc_ready_o, exp_alloc_ready());
      chk("rs1_busy", rs1_busy_o, rs1_addr_i != 5'd0 && pend[rs1_addr_i] != 0);
      chk("rs2_busy", rs2_busy_o, rs2_addr_i != 5'd0 && pend[rs2_addr_i] != 0);
      chk("idle", idle_o, model_idle());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_alu(input logic [4:0] rd, input logic [63:0] data, input logic wen);
    logic done = 1'b0;
    alu_valid_i = 1'b1; alu_rd_i = rd; alu_data_i = data; alu_wen_i = wen;
    for (int k = 0; k < 32 && !done; k++) begin
      tick();
      done = m_alu_took;
    end
    alu_valid_i = 1'b0;
    chk("alu_handshake", done, 1'b1);
  endtask

  task automatic send_lsu(input logic [4:0] rd, input logic [1:0] size, input logic uns,
                          input logic [2:0] off, input logic [63:0] rdata);
    logic done = 1'b0;
    lsu_valid_i = 1'b1; lsu_rd_i = rd; lsu_size_i = size;
    lsu_unsigned_i = uns; lsu_offset_i = off; lsu_rdata_i = rdata;
    for (int k = 0; k < 32 && !done; k++) begin
      tick();
      done = m_lsu_took;
    end
    lsu_valid_i = 1'b0;
    chk("lsu_handshake", done, 1'b1);
  endtask

  initial begin
    @(posedge clk);
    #1 cmp_en = 1'b1;
  end

  initial begin
    logic [9:0] pattern;
    rst = 1'b0;
    alu_valid_i = 0; alu_wen_i = 0; alu_rd_i = 0; alu_data_i = 0;
    lsu_valid_i = 0; lsu_unsigned_i = 0; lsu_rd_i = 0; lsu_size_i = 0;
    lsu_offset_i = 0; lsu_rdata_i = 0;
    alloc_valid_i = 0; alloc_rd_i = 0; rs1_addr_i = 0; rs2_addr_i = 0;
    tick(); tick();
    chk("reset_we", we_o_reg, 1'b0);
    chk("reset_waddr", waddr_o_reg, 5'd0);
    chk("reset_wdata", wdata_o_reg, 64'd0);
    chk("reset_idle", idle_o, 1'b1);
    rst = 1'b1;

    send_alu(5'd5, 64'h1234, 1'b1);
    chk("alu_we", we_o_reg, 1'b1);
    chk("alu_waddr", waddr_o_reg, 5'd5);
    chk("alu_wdata", wdata_o_reg, 64'h1234);
    tick();
    chk("alu_we_drop", we_o_reg, 1'b0);

    send_lsu(5'd9, 2'd0, 1'b0, 3'd7, 64'h80FF_0000_0000_0000);
    chk("lb_signed", wdata_o_reg, 64'hFFFF_FFFF_FFFF_FF80);
    send_lsu(5'd9, 2'd0, 1'b1, 3'd7, 64'h80FF_0000_0000_0000);
    chk("lb_unsigned", wdata_o_reg, 64'h80);
    send_lsu(5'd9, 2'd2, 1'b0, 3'd4, 64'h8000_0001_0000_0000);
    chk("lw_signed", wdata_o_reg, 64'hFFFF_FFFF_8000_0001);
    send_lsu(5'd10, 2'd1, 1'b0, 3'd3, 64'h0000_0000_9ABC_0000);
    chk("lh_signed", wdata_o_reg, 64'hFFFF_FFFF_FFFF_9ABC);

    // Both sources busy: expect four LSU grants, then one forced ALU grant.
    alu_valid_i = 1'b1; alu_wen_i = 1'b1; alu_rd_i = 5'd0; alu_data_i = 64'h55;
    lsu_valid_i = 1'b1; lsu_rd_i = 5'd0; lsu_size_i = 2'd3;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      pattern[i] = alu_ready_o;
      tick();
    end
    alu_valid_i = 1'b0; lsu_valid_i = 1'b0;
    chk("starve_pattern", pattern, 10'b10000_10000);
    tick();
    chk("rd0_no_write", we_o_reg, 1'b0);

    alloc_valid_i = 1'b1; alloc_rd_i = 5'd3;
    tick(); tick(); tick();
    alloc_valid_i = 1'b0; rs1_addr_i = 5'd3;
    #1;
    chk("rd3_busy", rs1_busy_o, 1'b1);
    chk("rd3_alloc_full", alloc_ready_o, 1'b0);
    for (int w = 0; w < 3; w++) begin
      send_alu(5'd3, 64'(w + 100), 1'b1);
      tick();
      chk("rd3_busy_drain", rs1_busy_o, w < 2);
    end
    chk("idle_after_drain", idle_o, 1'b1);

    alloc_valid_i = 1'b1; alloc_rd_i = 5'd7;
    tick();
    alloc_valid_i = 1'b0;
    send_alu(5'd7, 64'hAA, 1'b1);
    alloc_valid_i = 1'b1; alloc_rd_i = 5'd7;
    tick();
    alloc_valid_i = 1'b0; rs2_addr_i = 5'd7;
    #1;
    chk("rd7_inc_dec", rs2_busy_o, 1'b1);
    send_alu(5'd7, 64'hBB, 1'b1);
    tick();
    chk("rd7_cleared", rs2_busy_o, 1'b0);

    send_alu(5'd0, 64'hDEAD, 1'b1);
    chk("x0_write_we", we_o_reg, 1'b0);
    chk("x0_write_idle", idle_o, 1'b1);

    alloc_valid_i = 1'b1; alloc_rd_i = 5'd4;
    tick(); tick();
    alloc_valid_i = 1'b0;
    send_alu(5'd4, 64'hCAFE, 1'b1);
    alu_valid_i = 1'b1; lsu_valid_i = 1'b1; alloc_valid_i = 1'b1;
    rst = 1'b0;
    #1;
    chk("rst_alu_ready", alu_ready_o, 1'b0);
    chk("rst_lsu_ready", lsu_ready_o, 1'b0);
    chk("rst_alloc_ready", alloc_ready_o, 1'b0);
    tick();
    rst = 1'b1; alu_valid_i = 1'b0; lsu_valid_i = 1'b0; alloc_valid_i = 1'b0;
    rs1_addr_i = 5'd4; rs2_addr_i = 5'd4;
    #1;
    chk("rst_drop_we", we_o_reg, 1'b0);
    chk("rst_busy1", rs1_busy_o, 1'b0);
    chk("rst_busy2", rs2_busy_o, 1'b0);
    chk("rst_idle", idle_o, 1'b1);

    for (int c = 0; c < 3000; c++) begin
      if (!alu_valid_i || m_alu_took) begin
        alu_valid_i = ($urandom_range(0, 9) < 6);
        alu_wen_i   = ($urandom_range(0, 3) != 0);
        alu_rd_i    = 5'($urandom_range(0, 7));
        alu_data_i  = {$urandom, $urandom};
      end
      if (!lsu_valid_i || m_lsu_took) begin
        lsu_valid_i    = ($urandom_range(0, 9) < 6);
        lsu_rd_i       = 5'($urandom_range(0, 7));
        lsu_size_i     = 2'($urandom_range(0, 3));
        lsu_unsigned_i = 1'($urandom_range(0, 1));
        lsu_offset_i   = 3'($urandom_range(0, 7));
        lsu_rdata_i    = {$urandom, $urandom};
      end
      alloc_valid_i = ($urandom_range(0, 9) < 4);
      alloc_rd_i    = 5'($urandom_range(0, 7));
      rs1_addr_i    = 5'($urandom_range(0, 7));
      rs2_addr_i    = 5'($urandom_range(0, 7));
      rst           = ($urandom_range(0, 199) != 0);
      tick();
    end

    alu_valid_i = 1'b0; lsu_valid_i = 1'b0; alloc_valid_i = 1'b0; rst = 1'b1;
    tick(); tick(); tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
